adder_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one registered nibble adder among `NREQ` requesters. Each requester presents two operands with a valid/ready handshake. The block grants one requester at a time, computes the full-width sum in a dedicated adder stage, and returns the sum tagged with the requester index on a valid/ready result channel. It sits between the user-input decode logic and the `uo_out` driver in the tile top, replacing per-requester adders with a single shared one.

---
 rtl/adder_share_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter that time-shares one registered
// adder among NREQ requesters and returns each sum tagged with the index of
// the requester that supplied the operands.
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [W:0]        res_data,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [IDW-1:0] ptr_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [IDW-1:0] id_r;

  logic [IDW:0]   cand_s;
  logic [IDW-1:0] cand_idx_s;
  logic           hit_s;
  logic           found_s;
  logic [IDW-1:0] grant_idx_s;
  logic [W-1:0]   sel_a_s;
  logic [W-1:0]   sel_b_s;
  logic           can_take_s;
  logic           take_s;

  // Round-robin search: first valid requester at or after ptr, with wrap.
  always_comb begin
    cand_s      = {(IDW+1){1'b0}};
    cand_idx_s  = {IDW{1'b0}};
    hit_s       = 1'b0;
    found_s     = 1'b0;
    grant_idx_s = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr_r} + (IDW+1)'(k);
      cand_s = (cand_s >= (IDW+1)'(NREQ)) ? (cand_s - (IDW+1)'(NREQ)) : cand_s;
      cand_idx_s  = cand_s[IDW-1:0];
      hit_s       = ~found_s & req_valid[cand_idx_s];
      grant_idx_s = hit_s ? cand_idx_s : grant_idx_s;
      found_s     = found_s | hit_s;
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a_s = {W{1'b0}};
    sel_b_s = {W{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      sel_a_s = sel_a_s | (req_a[j*W +: W] & {W{grant_idx_s == IDW'(j)}});
      sel_b_s = sel_b_s | (req_b[j*W +: W] & {W{grant_idx_s == IDW'(j)}});
    end
  end

  // A grant is possible when idle, or when the held result leaves this cycle.
  always_comb begin
    can_take_s = (state_r == ST_IDLE) || ((state_r == ST_OUT) && res_ready);
    take_s     = rst_n && found_s && can_take_s;
    if (take_s) begin
      req_ready = NREQ'(1) << grant_idx_s;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Next-state logic for the IDLE/ADD/OUT sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_s = ST_ADD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        state_s = ST_OUT;
      end
      ST_OUT: begin
        if (res_ready) begin
          state_s = take_s ? ST_ADD : ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and pointer advance on every accepted transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= {IDW{1'b0}};
      a_r   <= {W{1'b0}};
      b_r   <= {W{1'b0}};
      id_r  <= {IDW{1'b0}};
    end else if (take_s) begin
      ptr_r <= (grant_idx_s == IDW'(NREQ-1)) ? {IDW{1'b0}} : (grant_idx_s + IDW'(1));
      a_r   <= sel_a_s;
      b_r   <= sel_b_s;
      id_r  <= grant_idx_s;
    end else begin
      ptr_r <= ptr_r;
      a_r   <= a_r;
      b_r   <= b_r;
      id_r  <= id_r;
    end
  end

  // Shared adder stage and result holding register; carry is always kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= {(W+1){1'b0}};
      res_id    <= {IDW{1'b0}};
    end else if (state_r == ST_ADD) begin
      res_valid <= 1'b1;
      res_data  <= {1'b0, a_r} + {1'b0, b_r};
      res_id    <= id_r;
    end else if ((state_r == ST_OUT) && res_ready) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= res_valid;
    end
  end

  // Busy flag registered alongside the state so it stays glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_s != ST_IDLE);
    end
  end

endmodule
